// File: rtl/sd_cmd_serial_engine.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7 and receives an optional
// 48/136-bit response. Define SD_CMD_BUSY_EN to add the R1b busy wait on DAT0.
module sd_cmd_serial_engine #(
    parameter int INIT_DELAY   = 64,
    parameter int NCR_TIMEOUT  = 64,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic         SD_CLK_IN,
    input  logic         RST_IN,
    input  logic         START_IN,
    input  logic [39:0]  CMD_IN,
    input  logic [1:0]   RSP_TYPE_IN,
    input  logic         BUSY_IN,
    input  logic         cmd_dat_i,
    input  logic         dat0_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic         BUSY_OUT,
    output logic         DONE_OUT,
    output logic [5:0]   RSP_IDX_OUT,
    output logic [119:0] RSP_OUT,
    output logic [3:0]   ERR_OUT
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_TX,
        S_NCR,
        S_RX,
`ifdef SD_CMD_BUSY_EN
        S_BUSY,
`endif
        S_DONE
    } state_t;

    localparam logic [15:0] INIT_LAST = 16'(INIT_DELAY - 1);
    localparam logic [15:0] NCR_LAST  = 16'(NCR_TIMEOUT - 1);
    localparam logic [15:0] TX_LAST   = 16'd47;
`ifdef SD_CMD_BUSY_EN
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
`endif

    state_t        state, state_nxt;
    logic [15:0]   cnt;
    logic [39:0]   tx_sr;
    logic [6:0]    crc;
    logic [6:0]    rx_crc;
    logic [1:0]    rsp_type;
    logic [119:0]  rsp;
    logic [5:0]    idx;
    logic [3:0]    err;
    logic          rsp_long;
    logic [15:0]   rx_end;
    logic [15:0]   data_hi;
    logic [15:0]   crc_lo;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // RX cnt = frame bit number - 1 (the start bit is consumed in NCR).
    assign rsp_long = (rsp_type == 2'b10);
    assign rx_end   = rsp_long ? 16'd134 : 16'd46;
    assign data_hi  = rx_end - 16'd8;
    assign crc_lo   = rsp_long ? 16'd7 : 16'd0;

`ifdef SD_CMD_BUSY_EN
    logic busy_req;

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN)
            busy_req <= 1'b0;
        else if (state == S_IDLE && START_IN)
            busy_req <= BUSY_IN;
    end
`else
    logic unused_busy;
    assign unused_busy = BUSY_IN ^ dat0_i;
`endif

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_oe_o  = 1'b0;
        cmd_out_o = 1'b1;
        BUSY_OUT  = 1'b0;
        DONE_OUT  = 1'b0;
        case (state)
            S_INIT: begin
                cmd_oe_o = 1'b1;
                if (cnt == INIT_LAST)
                    state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (START_IN)
                    state_nxt = S_TX;
            end
            S_TX: begin
                cmd_oe_o = 1'b1;
                BUSY_OUT = 1'b1;
                // Command bits, then CRC shifted out MSB first, then the end bit.
                if (cnt < 16'd40)
                    cmd_out_o = tx_sr[39];
                else if (cnt < TX_LAST)
                    cmd_out_o = crc[6];
                if (cnt == TX_LAST)
                    state_nxt = (rsp_type == 2'b00) ? S_DONE : S_NCR;
            end
            S_NCR: begin
                BUSY_OUT = 1'b1;
                if (cnt >= 16'd2 && !cmd_dat_i)
                    state_nxt = S_RX;
                else if (cnt == NCR_LAST)
                    state_nxt = S_DONE;
            end
            S_RX: begin
                BUSY_OUT = 1'b1;
                if (cnt == rx_end) begin
`ifdef SD_CMD_BUSY_EN
                    state_nxt = busy_req ? S_BUSY : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef SD_CMD_BUSY_EN
            S_BUSY: begin
                BUSY_OUT = 1'b1;
                if ((cnt >= 16'd2 && dat0_i) || cnt == BUSY_LAST)
                    state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                BUSY_OUT  = 1'b1;
                DONE_OUT  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            cnt      <= '0;
            tx_sr    <= '0;
            crc      <= '0;
            rx_crc   <= '0;
            rsp_type <= '0;
            rsp      <= '0;
            idx      <= '0;
            err      <= '0;
        end else begin
            cnt <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (START_IN) begin
                        tx_sr    <= CMD_IN;
                        rsp_type <= RSP_TYPE_IN;
                        crc      <= '0;
                        rx_crc   <= '0;
                        rsp      <= '0;
                        idx      <= '0;
                        err      <= '0;
                    end
                end
                S_TX: begin
                    tx_sr <= {tx_sr[38:0], 1'b0};
                    if (cnt < 16'd40)
                        crc <= crc7_step(crc, tx_sr[39]);
                    else
                        crc <= {crc[5:0], 1'b0};
                end
                S_NCR: begin
                    crc <= '0;
                    if (state_nxt == S_DONE)
                        err[0] <= 1'b1;
                end
                S_RX: begin
                    if (cnt >= crc_lo && cnt <= data_hi)
                        crc <= crc7_step(crc, cmd_dat_i);
                    if (!rsp_long && cnt >= 16'd1 && cnt <= 16'd6)
                        idx <= {idx[4:0], cmd_dat_i};
                    if (cnt >= 16'd7 && cnt <= data_hi)
                        rsp <= {rsp[118:0], cmd_dat_i};
                    if (cnt > data_hi && cnt < rx_end)
                        rx_crc <= {rx_crc[5:0], cmd_dat_i};
                    // Errors are only flagged; the frame is always received in full.
                    if (cnt == rx_end) begin
                        if (!cmd_dat_i)
                            err[2] <= 1'b1;
                        if (rsp_type != 2'b11 && crc != rx_crc)
                            err[1] <= 1'b1;
                    end
                end
`ifdef SD_CMD_BUSY_EN
                S_BUSY: begin
                    if (state_nxt == S_DONE && !(cnt >= 16'd2 && dat0_i))
                        err[3] <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign RSP_OUT     = rsp;
    assign RSP_IDX_OUT = idx;
    assign ERR_OUT     = err;

endmodule
